// File: rtl/mouse_position_tracker_if.sv
// Mouse coordinate bus: PS/2 byte stream in, clamped fixed-point cursor and button state out.
`default_nettype none

interface mouse_position_tracker_if;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic [31:0] x_mouse;
  logic [31:0] y_mouse;
  logic        btn_left;
  logic        btn_right;
  logic        pos_valid;
  logic        sync_err;

  modport master (
    input  byte_valid, byte_data,
    output x_mouse, y_mouse, btn_left, btn_right, pos_valid, sync_err
  );

  modport slave (
    output byte_valid, byte_data,
    input  x_mouse, y_mouse, btn_left, btn_right, pos_valid, sync_err
  );
endinterface

`default_nettype wire

// File: rtl/mouse_position_tracker.sv
// mouse_position_tracker: assembles 3-byte PS/2 packets and integrates deltas into a clamped cursor.
// Revision 1.0
`default_nettype none

module mouse_position_tracker #(
  parameter int SCREEN_W       = 640,
  parameter int SCREEN_H       = 480,
  parameter int INIT_X         = 320,
  parameter int INIT_Y         = 240,
  parameter int FRAC_BITS      = 12,
  parameter int TIMEOUT_CYCLES = 2000000
) (
  input  wire logic             clk,
  input  wire logic             rst,
  mouse_position_tracker_if.master bus
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic signed [15:0] C_X_MAX = 16'(SCREEN_W - 1);
  localparam logic signed [15:0] C_Y_MAX = 16'(SCREEN_H - 1);

  typedef enum logic [1:0] {
    WAIT_B0 = 2'd0,
    WAIT_B1 = 2'd1,
    WAIT_B2 = 2'd2
  } state_t;

  state_t                   state, state_nxt;
  logic [CNT_W-1:0]         tmo_cnt;
  // Header kept as {yovf, xovf, ysign, xsign, right, left}
  logic [5:0]               hdr;
  logic [7:0]               dx_lo;
  logic signed [15:0]       x_pos, y_pos;
  logic                     pos_valid_r, sync_err_r;
  logic                     btn_l_r, btn_r_r;

  logic                     timeout_hit, hdr_ok, dx_take, apply, drop;
  logic signed [15:0]       dx, dy, x_sum, y_sum;

  function automatic logic signed [15:0] clamp(input logic signed [15:0] v,
                                               input logic signed [15:0] hi);
    if (v < 16'sd0)   return 16'sd0;
    else if (v > hi)  return hi;
    else              return v;
  endfunction

  assign timeout_hit = (state != WAIT_B0) && (tmo_cnt == CNT_W'(TIMEOUT_CYCLES));

  always_comb begin
    state_nxt = state;
    hdr_ok    = 1'b0;
    dx_take   = 1'b0;
    apply     = 1'b0;
    drop      = 1'b0;
    // A timeout restarts framing, and a byte arriving that same cycle is judged as a header
    if (state == WAIT_B0 || timeout_hit) begin
      state_nxt = WAIT_B0;
      drop      = timeout_hit;
      if (bus.byte_valid) begin
        if (bus.byte_data[3]) begin
          hdr_ok    = 1'b1;
          state_nxt = WAIT_B1;
        end else begin
          drop = 1'b1;
        end
      end
    end else if (bus.byte_valid) begin
      if (state == WAIT_B1) begin
        dx_take   = 1'b1;
        state_nxt = WAIT_B2;
      end else begin
        apply     = 1'b1;
        state_nxt = WAIT_B0;
      end
    end
  end

  assign dx    = hdr[4] ? 16'sd0 : {{7{hdr[2]}}, hdr[2], dx_lo};
  assign dy    = hdr[5] ? 16'sd0 : {{7{hdr[3]}}, hdr[3], bus.byte_data};
  assign x_sum = x_pos + dx;
  assign y_sum = y_pos - dy;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= WAIT_B0;
      tmo_cnt     <= '0;
      hdr         <= '0;
      dx_lo       <= '0;
      x_pos       <= 16'(INIT_X);
      y_pos       <= 16'(INIT_Y);
      btn_l_r     <= 1'b0;
      btn_r_r     <= 1'b0;
      pos_valid_r <= 1'b0;
      sync_err_r  <= 1'b0;
    end else begin
      state       <= state_nxt;
      pos_valid_r <= apply;
      sync_err_r  <= drop;
      if (state_nxt == WAIT_B0 || bus.byte_valid)
        tmo_cnt <= '0;
      else
        tmo_cnt <= tmo_cnt + CNT_W'(1);
      if (hdr_ok)
        hdr <= {bus.byte_data[7:4], bus.byte_data[1:0]};
      if (dx_take)
        dx_lo <= bus.byte_data;
      if (apply) begin
        x_pos   <= clamp(x_sum, C_X_MAX);
        y_pos   <= clamp(y_sum, C_Y_MAX);
        btn_l_r <= hdr[0];
        btn_r_r <= hdr[1];
      end
    end
  end

  assign bus.x_mouse   = 32'($unsigned(x_pos)) << FRAC_BITS;
  assign bus.y_mouse   = 32'($unsigned(y_pos)) << FRAC_BITS;
  assign bus.btn_left  = btn_l_r;
  assign bus.btn_right = btn_r_r;
  assign bus.pos_valid = pos_valid_r;
  assign bus.sync_err  = sync_err_r;

endmodule

`default_nettype wire

// File: tb/tb_mouse_position_tracker.sv
// Bench for mouse_position_tracker: packet-level reference model plus literal spot checks.
`default_nettype none

module tb_mouse_position_tracker;

  localparam int TMO  = 40;
  localparam int W    = 640;
  localparam int H    = 480;
  localparam int IX   = 320;
  localparam int IY   = 240;
  localparam int FRAC = 12;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  mouse_position_tracker_if bus ();

  mouse_position_tracker #(
    .SCREEN_W(W), .SCREEN_H(H), .INIT_X(IX), .INIT_Y(IY),
    .FRAC_BITS(FRAC), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // Reference model state
  int         m_x, m_y, m_idx, m_idle;
  bit         m_l, m_r, m_pv, m_se;
  logic [7:0] p0, p1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  function automatic int clampi(input int v, input int hi);
    if (v < 0) return 0;
    if (v > hi) return hi;
    return v;
  endfunction

  function automatic int delta9(input bit sgn, input logic [7:0] lo, input bit ovf);
    if (ovf) return 0;
    return sgn ? int'(lo) - 256 : int'(lo);
  endfunction

  initial begin
    forever begin
      @(posedge clk);
      if (rst) begin
        m_x = IX; m_y = IY; m_l = 0; m_r = 0;
        m_idx = 0; m_idle = 0; m_pv = 0; m_se = 0;
      end else begin
        automatic bit err = 0;
        automatic bit pv  = 0;
        if (m_idx != 0 && m_idle >= TMO) begin
          m_idx = 0;
          err   = 1;
        end
        if (bus.byte_valid) begin
          if (m_idx == 0) begin
            if (bus.byte_data[3]) begin
              p0 = bus.byte_data;
              m_idx = 1;
            end else begin
              err = 1;
            end
          end else if (m_idx == 1) begin
            p1 = bus.byte_data;
            m_idx = 2;
          end else begin
            m_x = clampi(m_x + delta9(p0[4], p1, p0[6]), W - 1);
            m_y = clampi(m_y - delta9(p0[5], bus.byte_data, p0[7]), H - 1);
            m_l = p0[0];
            m_r = p0[1];
            pv  = 1;
            m_idx = 0;
          end
          m_idle = 0;
        end else if (m_idx == 0) begin
          m_idle = 0;
        end else begin
          m_idle++;
        end
        m_pv = pv;
        m_se = err;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        chk("model_x", bus.x_mouse, 32'(m_x) << FRAC);
        chk("model_y", bus.y_mouse, 32'(m_y) << FRAC);
        chk("model_btn_left", 32'(bus.btn_left), 32'(m_l));
        chk("model_btn_right", 32'(bus.btn_right), 32'(m_r));
        chk("model_pos_valid", 32'(bus.pos_valid), 32'(m_pv));
        chk("model_sync_err", 32'(bus.sync_err), 32'(m_se));
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.byte_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    bus.byte_valid = 1'b1;
    bus.byte_data  = b;
    @(negedge clk);
    bus.byte_valid = 1'b0;
  endtask

  task automatic send_pkt(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
    logic [7:0] bytes [3];
    bytes[0] = b0; bytes[1] = b1; bytes[2] = b2;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      bus.byte_valid = 1'b1;
      bus.byte_data  = bytes[i];
    end
    @(negedge clk);
    bus.byte_valid = 1'b0;
  endtask

  task automatic chk_pos(input string name, input int x, input int y);
    chk({name, "_x"}, bus.x_mouse, 32'(x) << FRAC);
    chk({name, "_y"}, bus.y_mouse, 32'(y) << FRAC);
  endtask

  initial begin
    bit found;
    bus.byte_valid = 1'b0;
    bus.byte_data  = 8'h00;

    do_reset();
    chk_pos("reset", 320, 240);
    chk("reset_btn", 32'({bus.btn_right, bus.btn_left}), 32'd0);
    chk("reset_flags", 32'({bus.pos_valid, bus.sync_err}), 32'd0);

    send_pkt(8'h08, 8'h05, 8'h03);
    chk("pkt1_pos_valid", 32'(bus.pos_valid), 32'd1);
    chk_pos("pkt1", 325, 237);
    @(negedge clk);
    chk("pkt1_pv_single", 32'(bus.pos_valid), 32'd0);

    do_reset();
    send_pkt(8'h19, 8'hF6, 8'h00);
    chk_pos("xneg", 310, 240);
    chk("xneg_left", 32'(bus.btn_left), 32'd1);

    send_pkt(8'h08, 8'hFF, 8'h00);
    send_pkt(8'h08, 8'h46, 8'h00);
    chk_pos("to635", 635, 240);
    send_pkt(8'h08, 8'h00, 8'hEE);
    chk_pos("to_y2", 635, 2);
    send_pkt(8'h08, 8'h14, 8'h00);
    chk_pos("xclamp_hi", 639, 2);
    send_pkt(8'h08, 8'h00, 8'h0A);
    chk_pos("yclamp_lo", 639, 0);

    send_pkt(8'h38, 8'h00, 8'h00);
    chk_pos("both_neg", 383, 256);
    send_pkt(8'h18, 8'h00, 8'h00);
    send_pkt(8'h18, 8'h00, 8'h00);
    chk_pos("xclamp_lo", 0, 256);
    send_pkt(8'h28, 8'h00, 8'h00);
    chk_pos("yclamp_hi", 0, 479);

    send_pkt(8'h48, 8'h7F, 8'h02);
    chk_pos("xovf", 0, 477);

    send_byte(8'h00);
    chk("bad_hdr_err", 32'(bus.sync_err), 32'd1);
    chk_pos("bad_hdr_hold", 0, 477);
    send_pkt(8'h08, 8'h05, 8'h03);
    chk_pos("after_bad", 5, 474);

    send_byte(8'h08);
    found = 1'b0;
    for (int i = 0; i < TMO + 5 && !found; i++) begin
      @(negedge clk);
      if (bus.sync_err) found = 1'b1;
    end
    chk("timeout_pulse", 32'(found), 32'd1);
    send_pkt(8'h08, 8'h01, 8'h01);
    chk_pos("after_tmo", 6, 473);

    // Next header lands on the exact cycle the timeout fires
    send_byte(8'h08);
    repeat (TMO - 1) @(negedge clk);
    send_pkt(8'h08, 8'h01, 8'h01);
    chk_pos("tmo_coincide", 7, 472);

    send_byte(8'h0B);
    send_byte(8'h05);
    do_reset();
    send_pkt(8'h0A, 8'h01, 8'h01);
    chk_pos("reset_midpkt", 321, 239);
    chk("midpkt_right", 32'(bus.btn_right), 32'd1);

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
